// File: rtl/add_sub_sched_pkg.sv
// rtl/add_sub_sched_pkg.sv - shared types and constants for the add_sub scheduler
package add_sub_sched_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/add_sub.sv
// rtl/add_sub.sv - 4-bit adder/subtractor; Cin=1 selects A + ~B + 1
module add_sub
    import add_sub_sched_pkg::*;
(
    output logic [DATA_W-1:0] R,
    output logic              Cout,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              Cin
);

    logic [DATA_W-1:0] b_eff;

    assign b_eff     = B ^ {DATA_W{Cin}};
    assign {Cout, R} = {1'b0, A} + {1'b0, b_eff} + {{DATA_W{1'b0}}, Cin};

endmodule

// File: rtl/add_sub_sched_rr_arbiter.sv
// rtl/add_sub_sched_rr_arbiter.sv - combinational round-robin grant starting at rr_ptr
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [ID_W-1:0]  grant_id,
    output logic             grant_vld
);

    always_comb begin
        int idx;
        idx       = 0;
        grant_id  = '0;
        grant_vld = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % N_REQ;
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/add_sub_sched.sv
// rtl/add_sub_sched.sv - round-robin scheduler sharing one add_sub; ADD_SUB_SCHED_OVF_EN adds rsp_ovf
module add_sub_sched
    import add_sub_sched_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [DATA_W*N_REQ-1:0] req_a,
    input  logic [DATA_W*N_REQ-1:0] req_b,
    input  logic [N_REQ-1:0]        req_sub,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DATA_W-1:0]       rsp_r,
    output logic                    rsp_cout
`ifdef ADD_SUB_SCHED_OVF_EN
    ,
    output logic                    rsp_ovf
`endif
);

    state_t            state, next_state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_id;
    logic              grant_vld;
    logic [DATA_W-1:0] op_a, op_b;
    logic              op_sub;
    logic [DATA_W-1:0] sum_r;
    logic              sum_cout;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic              sel_sub;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant_id  (grant_id),
        .grant_vld (grant_vld)
    );

    add_sub u_add_sub (
        .R    (sum_r),
        .Cout (sum_cout),
        .A    (op_a),
        .B    (op_b),
        .Cin  (op_sub)
    );

    assign sel_a   = req_a[int'(grant_id)*DATA_W +: DATA_W];
    assign sel_b   = req_b[int'(grant_id)*DATA_W +: DATA_W];
    assign sel_sub = req_sub[grant_id];

`ifdef ADD_SUB_SCHED_OVF_EN
    logic ovf_c;
    assign ovf_c = (op_a[DATA_W-1] == (op_b[DATA_W-1] ^ op_sub)) &&
                   (sum_r[DATA_W-1] != op_a[DATA_W-1]);
`endif

    always_comb begin
        next_state = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    req_ready[grant_id] = 1'b1;
                    next_state          = EXEC;
                end
            end
            EXEC:    next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_sub    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_r     <= '0;
            rsp_cout  <= 1'b0;
`ifdef ADD_SUB_SCHED_OVF_EN
            rsp_ovf   <= 1'b0;
`endif
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        op_sub <= sel_sub;
                        rsp_id <= grant_id;
                    end
                end
                EXEC: begin
                    rsp_r     <= sum_r;
                    rsp_cout  <= sum_cout;
                    rsp_valid <= 1'b1;
`ifdef ADD_SUB_SCHED_OVF_EN
                    rsp_ovf   <= ovf_c;
`endif
                end
                RESP: begin
                    // rsp_id still holds the served requester, so it seeds the next search
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= (rsp_id == ID_W'(N_REQ - 1)) ? '0 : rsp_id + ID_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_add_sub_sched.sv
// tb/tb_add_sub_sched.sv - scoreboard bench for add_sub_sched
module tb_add_sub_sched;

    localparam int N_REQ = 2;
    localparam int ID_W  = 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] req_ready;
    logic [4*N_REQ-1:0] req_a;
    logic [4*N_REQ-1:0] req_b;
    logic [N_REQ-1:0] req_sub;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [ID_W-1:0]  rsp_id;
    logic [3:0]       rsp_r;
    logic             rsp_cout;
`ifdef ADD_SUB_SCHED_OVF_EN
    logic             rsp_ovf;
`endif

    add_sub_sched #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_r     (rsp_r),
        .rsp_cout  (rsp_cout)
`ifdef ADD_SUB_SCHED_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [3:0]      r;
        logic            cout;
        logic            ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic exp_t mk(input logic [ID_W-1:0] id, input logic [3:0] r,
                                input logic cout, input logic ovf);
        exp_t e;
        e.id   = id;
        e.r    = r;
        e.cout = cout;
        e.ovf  = ovf;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_id), 32'hffff_ffff);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                chk("rsp_r", 32'(rsp_r), 32'(mon_e.r));
                chk("rsp_cout", 32'(rsp_cout), 32'(mon_e.cout));
`ifdef ADD_SUB_SCHED_OVF_EN
                chk("rsp_ovf", 32'(rsp_ovf), 32'(mon_e.ovf));
`endif
            end
        end
    end

    task automatic wait_grant(input int idx);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                chk("grant_onehot", 32'(req_ready), 32'(1 << idx));
                return;
            end
        end
        chk("grant_timeout", 32'(req_ready), 32'(1 << idx));
    endtask

    task automatic issue(input int idx, input logic [3:0] a, input logic [3:0] b, input logic sub);
        @(posedge clk); #1;
        req_a[4*idx +: 4] = a;
        req_b[4*idx +: 4] = b;
        req_sub[idx]      = sub;
        req_valid[idx]    = 1'b1;
        wait_grant(idx);
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        @(negedge clk);
        chk("lat_exec_no_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("lat_rsp_valid", 32'(rsp_valid), 32'd1);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        chk("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        chk({tag, "_rsp_r"}, 32'(rsp_r), 32'd0);
        chk({tag, "_rsp_cout"}, 32'(rsp_cout), 32'd0);
`ifdef ADD_SUB_SCHED_OVF_EN
        chk({tag, "_rsp_ovf"}, 32'(rsp_ovf), 32'd0);
`endif
    endtask

    initial begin
        int grants;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        rsp_ready = 1'b1;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // single add and the two subtract cases
        sb.push_back(mk(1'b0, 4'b0100, 1'b0, 1'b0));
        issue(0, 4'b0001, 4'b0011, 1'b0);
        wait_empty();
        sb.push_back(mk(1'b1, 4'b1001, 1'b0, 1'b1));
        issue(1, 4'b0101, 4'b1100, 1'b1);
        wait_empty();
        sb.push_back(mk(1'b0, 4'b1001, 1'b1, 1'b0));
        issue(0, 4'b1111, 4'b0110, 1'b1);
        wait_empty();

        // contention from reset: expect grants 0, 1, 0
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        sb.push_back(mk(1'b0, 4'b0110, 1'b1, 1'b1));
        sb.push_back(mk(1'b1, 4'b0001, 1'b1, 1'b0));
        sb.push_back(mk(1'b0, 4'b0110, 1'b1, 1'b1));
        req_a     = {4'b0011, 4'b1010};
        req_b     = {4'b0010, 4'b1100};
        req_sub   = 2'b10;
        req_valid = 2'b11;
        grants    = 0;
        for (int c = 0; c < 40 && grants < 3; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                chk("contention_grant", 32'(req_ready), (grants == 1) ? 32'd2 : 32'd1);
                grants++;
            end
        end
        chk("contention_grants", 32'(grants), 32'd3);
        @(posedge clk); #1;
        req_valid = '0;
        wait_empty();

        // backpressure: rr_ptr now 1, so req1 first, then req0
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        sb.push_back(mk(1'b1, 4'b0001, 1'b1, 1'b0));
        sb.push_back(mk(1'b0, 4'b0110, 1'b1, 1'b1));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_id", 32'(rsp_id), 32'd1);
            chk("bp_hold_r", 32'(rsp_r), 32'd1);
            chk("bp_hold_cout", 32'(rsp_cout), 32'd1);
            chk("bp_no_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_next_grant", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = '0;
        wait_empty();

        // reset during EXEC discards the operation
        @(posedge clk); #1;
        req_a[3:0]   = 4'b0001;
        req_b[3:0]   = 4'b0001;
        req_sub[0]   = 1'b0;
        req_valid[0] = 1'b1;
        wait_grant(0);
        @(posedge clk); #1;
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_valid", 32'(rsp_valid), 32'd0);
        end
        sb.push_back(mk(1'b0, 4'b1000, 1'b0, 1'b1));
        @(posedge clk); #1;
        req_a     = {4'b0101, 4'b0111};
        req_b     = {4'b0101, 4'b0001};
        req_sub   = 2'b00;
        req_valid = 2'b11;
        @(negedge clk);
        chk("rr_ptr_reset_grant", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("post_rst_exec", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("post_rst_resp", 32'(rsp_valid), 32'd1);
        wait_empty();

        // idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_req_ready", 32'(req_ready), 32'd0);
            chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        end

        chk("sb_final_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
